alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, named and ordered as follows.
- clk  input  1  rising-edge clock for all state
- rst  input  1  synchronous, active-high reset
REQ-002 SHALL expose these ports:
- instr_valid  input  1  upstream instruction present
- instr_ready  output  1  block can accept an instruction
- instr  input  32  RV32I instruction word
- alu_funct3  output  3  funct3 driven to ALU
- alu_funct7  output  7  funct7 driven to ALU
- alu_rs1  output  32  operand A driven to ALU
- alu_rs2  output  32  operand B driven to ALU
- alu_rd  input  32  registered ALU result, valid the cycle after an EXEC cycle
- wb_valid  output  1  one-cycle writeback strobe
- wb_addr  output  5  writeback destination index
- wb_data  output  32  writeback value
- illegal  output  1  one-cycle unsupported-instruction pulse
- dbg_addr  input  5  register-file debug read index
- dbg_data  output  32  combinational read of reg[dbg_addr]; 0 for index 0

Function
REQ-003 SHALL contain a 32x32 register file; x0 reads 0 and is never written.
REQ-004 SHALL implement FSM states IDLE, EXEC and WB.
REQ-005 instr_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge with instr_valid and instr_ready both 1.
REQ-006 Legal R-type SHALL be opcode 0110011 with funct3 in {000,100,110,111} and funct7 = 0000000, or funct7 = 0100000 only with funct3 000.
REQ-007 Legal I-type SHALL be opcode 0010011 with funct3 in {000,100,110,111}.
REQ-008 On a legal transfer, the block SHALL latch the following on that edge and move to EXEC:
- alu_funct3 = instr[14:12]
- alu_rs1 = reg[instr[19:15]]
- alu_rs2 = reg[instr[24:20]] for R-type, or sign-extended instr[31:20] for I-type
- alu_funct7 = instr[31:25] for R-type, or 0000000 for I-type (ADDI never subtracts)
- destination index = instr[11:7]
REQ-009 On an illegal transfer, the block SHALL assert illegal for exactly the next cycle, stay in IDLE, leave ALU outputs unchanged and write nothing.
REQ-010 EXEC SHALL last one cycle and then move to WB; the ALU captures the operands on the closing edge of EXEC.
REQ-011 In WB, wb_valid SHALL be 1, wb_addr SHALL equal the latched rd and wb_data SHALL equal alu_rd; the register write happens on the closing edge of WB unless rd = 0, and the FSM then returns to IDLE.
REQ-012 wb_valid SHALL also assert for rd = 0; only the write is suppressed.
REQ-013 alu_* outputs SHALL hold stable from EXEC through WB and the following IDLE until the next legal transfer.
REQ-014 Latency: accept at edge E0, EXEC cycle, WB cycle, register updated at E2, instr_ready = 1 again after E2; throughput SHALL be one instruction per 3 cycles.
REQ-015 A read of a register written by the previous instruction SHALL see the new value, which is guaranteed by the serial FSM; no forwarding SHALL be implemented.

Reset
REQ-016 While rst = 1 on an edge, the block SHALL:
- set state to IDLE
- clear all 31 writable registers to 0
- set alu_funct3, alu_funct7, alu_rs1, alu_rs2, wb_valid, wb_addr, wb_data and illegal to 0
REQ-017 rst in EXEC or WB SHALL abort the instruction with no register write; instr_ready SHALL be 1 in the cycle after rst deasserts.
REQ-018 Reset SHALL take priority over a simultaneous transfer; the instruction is dropped.

Verification
REQ-019 The bench SHALL model the ALU (registered: add/sub/xor/or/and) and cover:
- 0x00500093 (ADDI x1,x0,5), then 0xFFD00113 (ADDI x2,x0,-3) -> x1 = 0x00000005, x2 = 0xFFFFFFFD; wb_valid one cycle each, 3 cycles apart.
- 0x002081B3 (ADD x3,x1,x2) -> alu_funct7 = 0, wb_data = 0x00000002, dbg x3 = 2.
- 0x40208233 (SUB x4,x1,x2) -> alu_funct7 = 0100000, x4 = 0x00000008.
- 0x00700013 (ADDI x0,x0,7) -> wb_valid = 1, wb_addr = 0, wb_data = 7; dbg x0 = 0 afterward.
- 0x002092B3 (SLL, funct3 001) -> illegal pulses 1 cycle, no wb_valid, x5 stays 0, instr_ready = 1 the next cycle.
- ADDI x6,x0,9 with rst asserted during EXEC -> no wb_valid, x6 = 0, all registers 0, instr_ready = 1 after rst falls.

Source files
------------

// File: rtl/alu_issue.sv
// Issue/writeback sequencer for a registered RV32I ALU (ADD/SUB/XOR/OR/AND and immediate forms).
// Holds a 32x32 register file and runs each instruction serially: IDLE -> EXEC -> WB.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  input  logic [31:0] alu_rd,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NREGS   = 32;
  localparam logic [6:0]  OP_REG  = 7'b0110011;
  localparam logic [6:0]  OP_IMM  = 7'b0010011;
  localparam logic [6:0]  F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  state_e          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [6:0]      f7_q, f7_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] regs_q [NREGS];

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            f3_ok, is_r, is_i;
  logic [XLEN-1:0] src1, src2, imm;

  // Decode the incoming word and read its source registers.
  always_comb begin
    opcode = instr[6:0];
    f3     = instr[14:12];
    f7     = instr[31:25];
    f3_ok  = (f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b110) || (f3 == 3'b111);
    is_r   = (opcode == OP_REG) && f3_ok &&
             ((f7 == 7'b0) || ((f7 == F7_ALT) && (f3 == 3'b000)));
    is_i   = (opcode == OP_IMM) && f3_ok;
    imm    = {{20{instr[31]}}, instr[31:20]};
    src1   = (instr[19:15] == 5'd0) ? '0 : regs_q[instr[19:15]];
    src2   = (instr[24:20] == 5'd0) ? '0 : regs_q[instr[24:20]];
  end

  // Next-state and latched-operand logic.
  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    f7_d      = f7_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (is_r || is_i) begin
            state_d = EXEC;
            f3_d    = f3;
            f7_d    = is_r ? f7 : 7'b0;
            rs1_d   = src1;
            rs2_d   = is_r ? src2 : imm;
            rd_d    = instr[11:7];
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand and register-file update; rd = 0 writes are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      f3_q      <= '0;
      f7_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      f7_q      <= f7_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
      if ((state_q == WB) && (rd_q != 5'd0)) regs_q[rd_q] <= alu_rd;
    end
  end

  // Outputs: ALU operands straight from their holding registers, handshake decoded from state.
  always_comb begin
    instr_ready = (state_q == IDLE);
    alu_funct3  = f3_q;
    alu_funct7  = f7_q;
    alu_rs1     = rs1_q;
    alu_rs2     = rs2_q;
    wb_valid    = (state_q == WB);
    wb_addr     = rd_q;
    wb_data     = (state_q == WB) ? alu_rd : '0;
    illegal     = illegal_q;
    dbg_data    = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: registered ALU model, reference register file, directed and random instructions.
`timescale 1ns/1ps
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_rs1, alu_rs2, alu_rd;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_regs [32];
  logic [2:0]  exp_f3;
  logic [6:0]  exp_f7;
  logic [31:0] exp_rs1, exp_rs2;

  alu_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_rd(alu_rd), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Registered ALU: result appears the cycle after the operands are presented.
  always_ff @(posedge clk) begin
    case (alu_funct3)
      3'b000:  alu_rd <= alu_funct7[5] ? alu_rs1 - alu_rs2 : alu_rs1 + alu_rs2;
      3'b100:  alu_rd <= alu_rs1 ^ alu_rs2;
      3'b110:  alu_rd <= alu_rs1 | alu_rs2;
      3'b111:  alu_rd <= alu_rs1 & alu_rs2;
      default: alu_rd <= 32'hDEAD_BEEF;
    endcase
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] w);
    bit f3ok;
    f3ok = (w[14:12] == 3'd0) || (w[14:12] == 3'd4) || (w[14:12] == 3'd6) || (w[14:12] == 3'd7);
    if (w[6:0] == 7'h33) return f3ok && (w[31:25] == 7'h00 || (w[31:25] == 7'h20 && w[14:12] == 3'd0));
    if (w[6:0] == 7'h13) return f3ok;
    return 1'b0;
  endfunction

  // Architectural result of a legal instruction from the reference register file.
  function automatic logic [31:0] result(input logic [31:0] w);
    logic [31:0] a, b;
    bit r;
    r = (w[6:0] == 7'h33);
    a = ref_regs[w[19:15]];
    b = r ? ref_regs[w[24:20]] : 32'($signed(w[31:20]));
    case (w[14:12])
      3'd0:    return (r && w[30]) ? a - b : a + b;
      3'd4:    return a ^ b;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic chk_alu(input string tag);
    chk({tag, "_f3"}, 32'(alu_funct3), 32'(exp_f3));
    chk({tag, "_f7"}, 32'(alu_funct7), 32'(exp_f7));
    chk({tag, "_rs1"}, alu_rs1, exp_rs1);
    chk({tag, "_rs2"}, alu_rs2, exp_rs2);
  endtask

  task automatic chk_dbg(input logic [4:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    chk($sformatf("dbg_x%0d", idx), dbg_data, exp);
  endtask

  // Issue one instruction (called at a negedge) and follow it to completion.
  task automatic run_instr(input logic [31:0] w);
    logic [31:0] res;
    bit r;
    for (int i = 0; i < 8 && !instr_ready; i++) @(negedge clk);
    chk("ready_wait", 32'(instr_ready), 32'd1);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    if (legal(w)) begin
      r = (w[6:0] == 7'h33);
      exp_f3  = w[14:12];
      exp_f7  = r ? w[31:25] : 7'h00;
      exp_rs1 = ref_regs[w[19:15]];
      exp_rs2 = r ? ref_regs[w[24:20]] : 32'($signed(w[31:20]));
      res = result(w);
      chk_alu("exec");
      chk("exec_ready", 32'(instr_ready), 32'd0);
      chk("exec_wbv", 32'(wb_valid), 32'd0);
      chk("exec_illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      chk("wb_valid", 32'(wb_valid), 32'd1);
      chk("wb_addr", 32'(wb_addr), 32'(w[11:7]));
      chk("wb_data", wb_data, res);
      chk_alu("wb");
      @(negedge clk);
      if (w[11:7] != 5'd0) ref_regs[w[11:7]] = res;
      chk("post_wbv", 32'(wb_valid), 32'd0);
      chk("post_ready", 32'(instr_ready), 32'd1);
      chk_alu("post");
      chk_dbg(w[11:7], ref_regs[w[11:7]]);
    end else begin
      chk("ill_pulse", 32'(illegal), 32'd1);
      chk("ill_ready", 32'(instr_ready), 32'd1);
      chk("ill_wbv", 32'(wb_valid), 32'd0);
      chk_alu("ill");
      @(negedge clk);
      chk("ill_clear", 32'(illegal), 32'd0);
      chk("ill_wbv2", 32'(wb_valid), 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [2:0]  f3s [4];
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    f3s[0] = 3'd0; f3s[1] = 3'd4; f3s[2] = 3'd6; f3s[3] = 3'd7;
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    imm = $urandom;
    f3  = f3s[$urandom_range(0, 3)];
    case ($urandom_range(0, 3))
      0: begin
        f7 = (f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      1, 2: return {imm[11:0], rs1, f3, rd, 7'h13};
      default: begin
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 2))
          0: f7 = 7'h00;
          1: f7 = 7'h20;
          default: f7 = 7'($urandom);
        endcase
        case ($urandom_range(0, 2))
          0: op = 7'h33;
          1: op = 7'h13;
          default: op = 7'($urandom);
        endcase
        return {f7, rs2, rs1, f3, rd, op};
      end
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    exp_f3 = '0; exp_f7 = '0; exp_rs1 = '0; exp_rs2 = '0;
    rst = 1'b1;
    instr_valid = 1'b1;
    instr = 32'h00500093;
    dbg_addr = '0;

    // Reset wins over a simultaneous transfer.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    instr_valid = 1'b0;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_wbaddr", 32'(wb_addr), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk_alu("rst");
    @(negedge clk);
    chk("rst_nodrop_wbv", 32'(wb_valid), 32'd0);
    chk_dbg(5'd1, 32'd0);

    // Directed program.
    run_instr(32'h00500093);
    chk_dbg(5'd1, 32'h00000005);
    run_instr(32'hFFD00113);
    chk_dbg(5'd2, 32'hFFFFFFFD);
    run_instr(32'h002081B3);
    chk("add_f7", 32'(alu_funct7), 32'd0);
    chk_dbg(5'd3, 32'h00000002);
    run_instr(32'h40208233);
    chk("sub_f7", 32'(alu_funct7), 32'h20);
    chk_dbg(5'd4, 32'h00000008);
    run_instr(32'h00700013);
    chk_dbg(5'd0, 32'd0);
    run_instr(32'h002092B3);
    chk_dbg(5'd5, 32'd0);
    chk("sll_ready", 32'(instr_ready), 32'd1);

    // Random mix of legal and illegal words.
    for (int n = 0; n < 60; n++) run_instr(rand_instr());
    for (int i = 0; i < 32; i++) chk_dbg(5'(i), ref_regs[i]);

    // Reset during EXEC aborts ADDI x6,x0,9.
    instr = 32'h00900313;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_exec_ready", 32'(instr_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    exp_f3 = '0; exp_f7 = '0; exp_rs1 = '0; exp_rs2 = '0;
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_wbv", 32'(wb_valid), 32'd0);
    chk_alu("abort");
    @(negedge clk);
    chk("abort_wbv2", 32'(wb_valid), 32'd0);
    chk("abort_ready2", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 32; i++) chk_dbg(5'(i), 32'd0);

    // Block still works after the abort.
    run_instr(32'h00900313);
    chk_dbg(5'd6, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
